// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and its multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: 4-bit ALU operation codes, 2-bit MDU operation codes, MDU state enum.
package alu_pkg;

  // ALU operation codes driven by the decode stage.
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ADDU = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SUBU = 4'b1110;
  localparam logic [3:0] ALU_SLL  = 4'b1111;

  // MDU operation codes. Bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIN  = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Iterative radix-2 multiply/divide engine owning the architectural HI/LO registers.
// Latency: start at edge E0 -> done pulse and new HI/LO after edge E0+WIDTH+1.
// Backpressure: start is dropped while busy_o is high; HI/LO writes are dropped while busy.
// Ports: clk, rst (sync, active-high); start_i/op_i/x_i/y_i request; hi_we_i/lo_we_i
//        move-to writes of x_i; busy_o/done_o status; hi_o/lo_o architectural registers.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   x_q;      // raw dividend, needed for divide-by-zero HI
  logic [WIDTH-1:0]   mb_q;     // |y| (or raw y for unsigned ops)
  logic [2*WIDTH-1:0] acc_q;    // mul: {partial, multiplier}; div: {remainder, quotient}
  logic               neg_q;    // product/quotient must be negated
  logic               sx_q;     // remainder takes the dividend sign
  logic               dbz_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand preparation for the start cycle.
  logic             signed_op;
  logic [WIDTH-1:0] abs_x;
  logic [WIDTH-1:0] abs_y;

  assign signed_op = ~op_i[0];
  assign abs_x     = (signed_op && x_i[WIDTH-1]) ? -x_i : x_i;
  assign abs_y     = (signed_op && y_i[WIDTH-1]) ? -y_i : y_i;

  // One multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_next;

  assign madd     = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q})
                             : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign mul_next = {madd, acc_q[WIDTH-1:1]};

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. The remainder stays below
  // the divisor, so the truncated difference is exact.
  logic [WIDTH:0]     rsh;
  logic [WIDTH-1:0]   dsub;
  logic               fits;
  logic [2*WIDTH-1:0] div_next;

  assign rsh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign fits     = (rsh >= {1'b0, mb_q});
  assign dsub     = rsh[WIDTH-1:0] - mb_q;
  assign div_next = fits ? {dsub, acc_q[WIDTH-2:0], 1'b1}
                         : {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Sign correction applied when leaving FIN.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sx_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      x_q     <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      sx_q    <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (hi_we_i) hi_q <= x_i;
          if (lo_we_i) lo_q <= x_i;
          if (start_i) begin
            state_q <= MD_RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op_i;
            x_q     <= x_i;
            mb_q    <= abs_y;
            acc_q   <= {{WIDTH{1'b0}}, abs_x};
            neg_q   <= signed_op & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
            sx_q    <= signed_op & x_i[WIDTH-1];
            dbz_q   <= (y_i == '0);
          end
        end
        MD_RUN: begin
          acc_q <= op_q[1] ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) state_q <= MD_FIN;
        end
        MD_FIN: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dbz_q) begin
            hi_q <= x_q;
            lo_q <= '1;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with flags plus an iterative multiply/divide unit holding HI/LO.
// Latency: ALU result/flags combinational; MDU result WIDTH+1 cycles after start.
// Backpressure: md_busy high means md_start and mthi/mtlo are ignored; the hazard unit stalls.
// Ports: clk, rst; alu_ctrl/shamt/x/y -> result, zero_f, ovf; md_start/md_op -> md_busy,
//        md_done; hi_we/lo_we write x into hi/lo; hi/lo architectural registers.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_ctrl,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result,
  output logic             zero_f,
  output logic             ovf,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             md_busy,
  output logic             md_done,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = x + y;
  assign diff = x - y;

  always_comb begin
    result = '0;
    case (alu_ctrl)
      ALU_AND:  result = x & y;
      ALU_OR:   result = x | y;
      ALU_ADD:  result = sum;
      ALU_ADDU: result = sum;
      ALU_SUB:  result = diff;
      ALU_SUBU: result = diff;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (x < y)};
      ALU_XOR:  result = x ^ y;
      ALU_NOR:  result = ~(x | y);
      ALU_SLL:  result = x << shamt;
      ALU_SRL:  result = x >> shamt;
      ALU_SRA:  result = $signed(x) >>> shamt;
      default:  result = '0;
    endcase
  end

  // Signed overflow: operands agree in sign (add) or disagree (sub) and the
  // wrapped result flips away from x's sign.
  always_comb begin
    ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      ALU_SUB: ovf = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end

  assign zero_f = (result == '0);

  mdu_seq #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (md_op),
    .x_i     (x),
    .y_i     (y),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 and WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;

  // WIDTH=32 instance signals
  logic [3:0]  alu_ctrl;
  logic [4:0]  shamt;
  logic [31:0] x, y, result, hi, lo;
  logic        zero_f, ovf, md_start, md_busy, md_done, hi_we, lo_we;
  logic [1:0]  md_op;

  // WIDTH=8 instance signals
  logic [3:0]  alu_ctrl8;
  logic [2:0]  shamt8;
  logic [7:0]  x8, y8, result8, hi8, lo8;
  logic        zero_f8, ovf8, md_start8, md_busy8, md_done8;
  logic [1:0]  md_op8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .shamt(shamt), .x(x), .y(y),
    .result(result), .zero_f(zero_f), .ovf(ovf), .md_start(md_start), .md_op(md_op),
    .md_busy(md_busy), .md_done(md_done), .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl8), .shamt(shamt8), .x(x8), .y(y8),
    .result(result8), .zero_f(zero_f8), .ovf(ovf8), .md_start(md_start8), .md_op(md_op8),
    .md_busy(md_busy8), .md_done(md_done8), .hi_we(1'b0), .lo_we(1'b0), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one MDU op on the 32-bit instance and return edges from E0 to md_done.
  task automatic md32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int n);
    x = a; y = b; md_op = op; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    n = 0;
    while (!md_done && n < 100) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  seen_done;
    rst = 1'b1;
    alu_ctrl = 4'b0000; shamt = '0; x = '0; y = '0;
    md_start = 1'b0; md_op = 2'b00; hi_we = 1'b0; lo_we = 1'b0;
    alu_ctrl8 = 4'b0000; shamt8 = '0; x8 = '0; y8 = '0; md_start8 = 1'b0; md_op8 = 2'b00;

    tick(); tick();
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", md_busy, 0);
    check("rst_done", md_done, 0);
    check("rst_hi8", hi8, 0);
    check("rst_busy8", md_busy8, 0);
    rst = 1'b0;
    tick();

    // Combinational ALU vectors
    x = 32'h7FFF_FFFF; y = 32'h1; alu_ctrl = 4'b0010; #1;
    check("add_res", result, 32'h8000_0000);
    check("add_ovf", ovf, 1);
    alu_ctrl = 4'b1010; #1;
    check("addu_res", result, 32'h8000_0000);
    check("addu_ovf", ovf, 0);
    alu_ctrl = 4'b0000; #1;
    check("and_res", result, 32'h1);
    check("and_ovf", ovf, 0);
    alu_ctrl = 4'b1100; #1;
    check("nor_res", result, 32'h8000_0000);
    x = 32'h8000_0000; y = 32'h1; alu_ctrl = 4'b0110; #1;
    check("sub_ovf_res", result, 32'h7FFF_FFFF);
    check("sub_ovf", ovf, 1);
    x = 32'h1234_5678; y = 32'h1234_5678; alu_ctrl = 4'b0110; #1;
    check("sub_zero_res", result, 0);
    check("sub_zero_f", zero_f, 1);
    x = 32'h8000_0000; shamt = 5'd4; alu_ctrl = 4'b1001; #1;
    check("sra", result, 32'hF800_0000);
    alu_ctrl = 4'b1000; #1;
    check("srl", result, 32'h0800_0000);
    x = 32'h1; y = 32'hFFFF_FFFF; alu_ctrl = 4'b0011; #1;
    check("sltu", result, 1);
    alu_ctrl = 4'b0111; #1;
    check("slt", result, 0);
    check("slt_zero_f", zero_f, 1);
    alu_ctrl = 4'b0100; #1;
    check("default_res", result, 0);
    check("default_zero_f", zero_f, 1);

    // mult -3*7 with a start re-pulsed at E5 (must be ignored)
    x = 32'hFFFF_FFFD; y = 32'd7; md_op = 2'b00; md_start = 1'b1;
    tick();                                   // E0
    md_start = 1'b0;
    check("mult_busy_after_e0", md_busy, 1);
    tick(); tick(); tick(); tick();           // E1..E4
    x = 32'd100; y = 32'd5; md_op = 2'b11; md_start = 1'b1;
    tick();                                   // E5
    md_start = 1'b0;
    n = 5;
    while (!md_done && n < 100) begin
      tick();
      n++;
    end
    check("mult_latency", n, 33);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_busy_at_done", md_busy, 0);
    tick();
    check("mult_done_pulse", md_done, 0);

    md32(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    check("div_latency", n, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Back-to-back: start again in the md_done cycle
    md32(2'b11, 32'd7, 32'd0, n);
    check("divu0_latency", n, 33);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'd7);

    md32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 0);

    md32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h1);
    tick();

    // mthi while idle
    x = 32'h1234; hi_we = 1'b1;
    tick();
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'h1234);

    // mtlo while busy is dropped
    x = 32'd2; y = 32'd3; md_op = 2'b00; md_start = 1'b1;
    tick();
    md_start = 1'b0;
    tick(); tick();
    x = 32'hDEAD; lo_we = 1'b1;
    tick();
    lo_we = 1'b0; x = 32'h0;
    check("mtlo_busy_ignored", lo, 32'h1);
    n = 0;
    while (!md_done && n < 100) begin
      tick();
      n++;
    end
    check("mtlo_busy_done_lo", lo, 32'd6);
    check("mtlo_busy_done_hi", hi, 32'd0);
    tick();

    // Reset at E10 of a divide aborts with no done pulse
    x = 32'd100; y = 32'd7; md_op = 2'b11; md_start = 1'b1;
    tick();                                   // E0
    md_start = 1'b0;
    for (int i = 1; i < 10; i++) tick();      // E1..E9
    rst = 1'b1;
    tick();                                   // E10
    rst = 1'b0;
    check("abort_busy", md_busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (md_done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", seen_done, 0);

    // WIDTH=8 instance
    x8 = 8'hFF; y8 = 8'h02; md_op8 = 2'b01; md_start8 = 1'b1;
    tick();                                   // E0
    md_start8 = 1'b0;
    n = 0;
    while (!md_done8 && n < 100) begin
      tick();
      n++;
    end
    check("w8_multu_latency", n, 9);
    check("w8_multu_hi", hi8, 8'h01);
    check("w8_multu_lo", lo8, 8'hFE);
    x8 = 8'h81; shamt8 = 3'd1; alu_ctrl8 = 4'b1111; #1;
    check("w8_sll", result8, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
